// File: rtl/ccff_bitstream_loader_if.sv
// Bitstream word stream into the configuration-chain loader.
// Valid/ready handshake; a word transfers on an edge where both are high.
interface ccff_bitstream_loader_if #(
   parameter int unsigned WORD_W = 8
) ();

   logic [WORD_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;

   modport master (
      output cfg_data,
      output cfg_valid,
      input  cfg_ready
   );

   modport slave (
      input  cfg_data,
      input  cfg_valid,
      output cfg_ready
   );

endinterface

// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words MSB-first onto the configuration chain head and
// counts the ones that emerge from the chain tail during the load.
module ccff_bitstream_loader #(
   parameter int unsigned CHAIN_LEN = 64,
   parameter int unsigned WORD_W    = 8,
   parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic                   prog_clk,
   input  logic                   pReset,
   input  logic                   start,
   input  logic                   abort,
   ccff_bitstream_loader_if.slave cfg,
   output logic                   ccff_head,
   input  logic                   ccff_tail,
   output logic                   ccff_shift_en,
   output logic                   busy,
   output logic                   done,
   output logic [CNT_W-1:0]       bits_sent,
   output logic [CNT_W-1:0]       tail_ones
);

   localparam int unsigned NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int unsigned WT_W   = $clog2(NWORDS + 1);
   localparam int unsigned BL_W   = $clog2(WORD_W + 1);

   localparam logic [CNT_W-1:0] ChainEnd = CNT_W'(CHAIN_LEN);
   localparam logic [WT_W-1:0]  WordsEnd = WT_W'(NWORDS);
   localparam logic [BL_W-1:0]  WordBits = BL_W'(WORD_W);
   localparam logic [BL_W-1:0]  OneBit   = BL_W'(1);

   typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

   state_e             state_q, state_d;
   logic [WORD_W-1:0]  sreg_q, sreg_d;
   logic [BL_W-1:0]    bits_left_q, bits_left_d;
   logic [CNT_W-1:0]   bits_sent_q, bits_sent_d;
   logic [CNT_W-1:0]   tail_ones_q, tail_ones_d;
   logic [WT_W-1:0]    words_taken_q, words_taken_d;
   logic               in_load;
   logic               accept;

   assign in_load       = (state_q == StLoad);
   assign ccff_shift_en = in_load && (bits_left_q != '0) && (bits_sent_q < ChainEnd);
   // Ready during the last bit of the current word so words stream without a bubble.
   assign cfg.cfg_ready = in_load && (words_taken_q < WordsEnd) &&
                          ((bits_left_q == '0) || ((bits_left_q == OneBit) && ccff_shift_en));
   assign accept        = cfg.cfg_valid && cfg.cfg_ready;
   assign ccff_head     = ccff_shift_en ? sreg_q[WORD_W-1] : 1'b0;
   assign busy          = in_load;
   assign done          = (state_q == StDone);
   assign bits_sent     = bits_sent_q;
   assign tail_ones     = tail_ones_q;

   always_comb begin
      state_d       = state_q;
      sreg_d        = sreg_q;
      bits_left_d   = bits_left_q;
      bits_sent_d   = bits_sent_q;
      tail_ones_d   = tail_ones_q;
      words_taken_d = words_taken_q;

      if (ccff_shift_en) begin
         sreg_d      = sreg_q << 1;
         bits_left_d = bits_left_q - OneBit;
         bits_sent_d = bits_sent_q + CNT_W'(1);
         tail_ones_d = tail_ones_q + CNT_W'(ccff_tail);
      end

      // A new word overrides the buffer; the outgoing bit was already counted above.
      if (accept) begin
         sreg_d        = cfg.cfg_data;
         bits_left_d   = WordBits;
         words_taken_d = words_taken_q + WT_W'(1);
      end

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d       = StLoad;
               sreg_d        = '0;
               bits_left_d   = '0;
               bits_sent_d   = '0;
               tail_ones_d   = '0;
               words_taken_d = '0;
            end
         end
         StLoad: begin
            if (bits_sent_q == ChainEnd) begin
               state_d     = StDone;
               bits_left_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase

      if (abort) begin
         state_d     = StIdle;
         bits_left_d = '0;
      end
   end

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state_q       <= StIdle;
         sreg_q        <= '0;
         bits_left_q   <= '0;
         bits_sent_q   <= '0;
         tail_ones_q   <= '0;
         words_taken_q <= '0;
      end else begin
         state_q       <= state_d;
         sreg_q        <= sreg_d;
         bits_left_q   <= bits_left_d;
         bits_sent_q   <= bits_sent_d;
         tail_ones_q   <= tail_ones_d;
         words_taken_q <= words_taken_d;
      end
   end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a 16-bit and a 10-bit chain instance, each
// driving a modelled downstream shift chain, checked against expected bitstreams.
module tb_ccff_bitstream_loader;

   logic prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   logic       rst;
   logic       start_s [2];
   logic       abort_s [2];
   logic       head_w  [2];
   logic       shen_w  [2];
   logic       busy_w  [2];
   logic       done_w  [2];
   logic [4:0] bsent_a, tones_a;
   logic [3:0] bsent_b, tones_b;
   logic [15:0] chain_a;
   logic [9:0]  chain_b;
   logic        pre_req [2];
   logic [15:0] pre_val;

   int          total;
   int          bad;
   logic [15:0] exp_chain [2];
   logic [7:0]  wq [$];

   logic        s_shen, s_head, s_ready, s_busy, s_done;
   logic [31:0] s_bits, s_tail;

   ccff_bitstream_loader_if #(.WORD_W(8)) if_a ();
   ccff_bitstream_loader_if #(.WORD_W(8)) if_b ();

   ccff_bitstream_loader #(.CHAIN_LEN(16), .WORD_W(8)) u_dut_a (
      .prog_clk      (prog_clk),
      .pReset        (rst),
      .start         (start_s[0]),
      .abort         (abort_s[0]),
      .cfg           (if_a),
      .ccff_head     (head_w[0]),
      .ccff_tail     (chain_a[15]),
      .ccff_shift_en (shen_w[0]),
      .busy          (busy_w[0]),
      .done          (done_w[0]),
      .bits_sent     (bsent_a),
      .tail_ones     (tones_a)
   );

   ccff_bitstream_loader #(.CHAIN_LEN(10), .WORD_W(8)) u_dut_b (
      .prog_clk      (prog_clk),
      .pReset        (rst),
      .start         (start_s[1]),
      .abort         (abort_s[1]),
      .cfg           (if_b),
      .ccff_head     (head_w[1]),
      .ccff_tail     (chain_b[9]),
      .ccff_shift_en (shen_w[1]),
      .busy          (busy_w[1]),
      .done          (done_w[1]),
      .bits_sent     (bsent_b),
      .tail_ones     (tones_b)
   );

   // Downstream tile chains: head enters at bit 0, tail leaves from the top.
   always @(posedge prog_clk) begin
      if (pre_req[0]) chain_a <= pre_val;
      else if (shen_w[0]) chain_a <= {chain_a[14:0], head_w[0]};
      if (pre_req[1]) chain_b <= pre_val[9:0];
      else if (shen_w[1]) chain_b <= {chain_b[8:0], head_w[1]};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sample(input int d);
      if (d == 0) begin
         s_shen = shen_w[0]; s_head = head_w[0]; s_ready = if_a.cfg_ready;
         s_busy = busy_w[0]; s_done = done_w[0];
         s_bits = 32'(bsent_a); s_tail = 32'(tones_a);
      end else begin
         s_shen = shen_w[1]; s_head = head_w[1]; s_ready = if_b.cfg_ready;
         s_busy = busy_w[1]; s_done = done_w[1];
         s_bits = 32'(bsent_b); s_tail = 32'(tones_b);
      end
   endtask

   task automatic drive(input int d, input logic v, input logic [7:0] data);
      if (d == 0) begin
         if_a.cfg_valid = v; if_a.cfg_data = data;
      end else begin
         if_b.cfg_valid = v; if_b.cfg_data = data;
      end
   endtask

   task automatic preload(input int d, input logic [15:0] v);
      @(negedge prog_clk);
      pre_val    = v;
      pre_req[d] = 1'b1;
      @(negedge prog_clk);
      pre_req[d] = 1'b0;
      exp_chain[d] = (d == 0) ? v : {6'b0, v[9:0]};
   endtask

   task automatic pulse_start(input int d);
      @(negedge prog_clk);
      start_s[d] = 1'b1;
      @(negedge prog_clk);
      start_s[d] = 1'b0;
   endtask

   task automatic check_all_zero(input int d, input string tag);
      sample(d);
      check({tag, "_ready"}, 32'(s_ready), 0);
      check({tag, "_head"}, 32'(s_head), 0);
      check({tag, "_shen"}, 32'(s_shen), 0);
      check({tag, "_busy"}, 32'(s_busy), 0);
      check({tag, "_done"}, 32'(s_done), 0);
      check({tag, "_bits_sent"}, s_bits, 0);
      check({tag, "_tail_ones"}, s_tail, 0);
   endtask

   // Full load of the words in wq; 'gap' starved cycles are inserted before each later word.
   task automatic run_load(input int d, input int gap, input string tag);
      int L, nw, widx, gap_cnt, first_s, last_s, bubbles, done_cyc, ones, nbits;
      bit pend, late_ready;
      logic [7:0] pend_w, w;
      logic [15:0] gv, eb, chain_now;
      logic v;
      L = (d == 0) ? 16 : 10;
      nw = (L + 7) / 8;
      widx = 0; gap_cnt = 0; first_s = -1; last_s = -1; bubbles = 0; done_cyc = -1;
      ones = 0; nbits = 0; pend = 0; late_ready = 0; pend_w = '0; gv = '0; eb = '0;
      for (int i = 0; i < L; i++) if (exp_chain[d][i]) ones++;
      for (int i = 0; i < L; i++) begin
         w  = wq[i/8];
         eb = {eb[14:0], w[7-(i%8)]};
      end
      pulse_start(d);
      for (int cyc = 0; cyc < 300; cyc++) begin
         #1;
         sample(d);
         if (cyc == 0) check({tag, "_busy"}, 32'(s_busy), 1);
         if (pend) begin
            check({tag, "_msb_latency"}, 32'({s_shen, s_head}), 32'({1'b1, pend_w[7]}));
            pend = 0;
         end
         if (s_shen) begin
            gv = {gv[14:0], s_head};
            nbits++;
            if (first_s < 0) first_s = cyc;
            last_s = cyc;
         end else if (first_s >= 0 && nbits < L) begin
            bubbles++;
         end
         if (widx == nw && s_ready) late_ready = 1;
         if (s_done) begin
            done_cyc = cyc;
            break;
         end
         if (widx > 0 && s_ready && !s_shen && gap_cnt > 0) gap_cnt--;
         v = (widx < nw) && (widx == 0 || gap_cnt == 0);
         if (v) drive(d, 1'b1, wq[widx]);
         else drive(d, 1'b0, 8'h00);
         if (v && s_ready) begin
            pend = 1; pend_w = wq[widx]; widx++; gap_cnt = gap;
         end
         @(negedge prog_clk);
      end
      drive(d, 1'b0, 8'h00);
      chain_now = (d == 0) ? chain_a : {6'b0, chain_b};
      check({tag, "_done_seen"}, 32'(done_cyc >= 0), 1);
      check({tag, "_shift_count"}, nbits, L);
      check({tag, "_head_bits"}, 32'(gv), 32'(eb));
      check({tag, "_starved_cycles"}, bubbles, gap * (nw - 1));
      // Last shift edge sets bits_sent; DONE is registered on the following edge.
      check({tag, "_done_latency"}, done_cyc - last_s, 2);
      check({tag, "_ready_after_last_word"}, 32'(late_ready), 0);
      check({tag, "_bits_sent"}, s_bits, L);
      check({tag, "_tail_ones"}, s_tail, ones);
      check({tag, "_chain"}, 32'(chain_now), 32'(eb));
      exp_chain[d] = eb;
   endtask

   // Start a load and stream random words until n shifts have gone out.
   task automatic feed_until(input int d, input int n);
      int nsh;
      nsh = 0;
      pulse_start(d);
      for (int cyc = 0; cyc < 100; cyc++) begin
         #1;
         sample(d);
         if (nsh == n) break;
         if (s_shen) nsh++;
         drive(d, 1'b1, 8'($urandom));
         @(negedge prog_clk);
      end
      drive(d, 1'b0, 8'h00);
      check("feed_reached", nsh, n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      pre_val = '0;
      for (int i = 0; i < 2; i++) begin
         start_s[i] = 1'b0; abort_s[i] = 1'b0; pre_req[i] = 1'b0;
         drive(i, 1'b0, 8'h00);
      end
      repeat (3) @(negedge prog_clk);
      rst = 1'b0;
      #1;
      check_all_zero(0, "reset_a");
      check_all_zero(1, "reset_b");

      // Back-to-back words, then the same words with starved gaps.
      preload(0, 16'(($urandom)));
      wq = '{8'hA5, 8'h3C};
      run_load(0, 0, "t1");
      wq = '{8'hA5, 8'h3C};
      run_load(0, 5, "t2");

      // Partial last word on the 10-bit chain.
      preload(1, 16'h02C5);
      wq = '{8'hFF, 8'hC0};
      run_load(1, 0, "t3");

      // Readback popcount of a known chain, then reload.
      preload(0, 16'h00F3);
      wq = '{8'h00, 8'h00};
      run_load(0, 0, "t4_zeros");
      wq = '{8'hA5, 8'h3C};
      run_load(0, 0, "t4_reload");

      for (int r = 0; r < 8; r++) begin
         int d;
         d = int'($urandom_range(0, 1));
         wq.delete();
         wq.push_back(8'($urandom));
         wq.push_back(8'($urandom));
         run_load(d, int'($urandom_range(0, 3)), "rand");
      end

      // Abort mid-load.
      feed_until(0, 5);
      abort_s[0] = 1'b1;
      @(negedge prog_clk);
      abort_s[0] = 1'b0;
      #1;
      sample(0);
      check("t5_shen", 32'(s_shen), 0);
      check("t5_busy", 32'(s_busy), 0);
      check("t5_ready", 32'(s_ready), 0);
      check("t5_done", 32'(s_done), 0);
      @(negedge prog_clk);
      abort_s[0] = 1'b1;
      start_s[0] = 1'b1;
      @(negedge prog_clk);
      abort_s[0] = 1'b0;
      start_s[0] = 1'b0;
      #1;
      sample(0);
      check("t5_abort_beats_start", 32'(s_busy), 0);
      pulse_start(0);
      #1;
      sample(0);
      check("t5_restart_bits_sent", s_bits, 0);
      check("t5_restart_tail_ones", s_tail, 0);
      check("t5_restart_busy", 32'(s_busy), 1);
      check("t5_restart_ready", 32'(s_ready), 1);
      abort_s[0] = 1'b1;
      @(negedge prog_clk);
      abort_s[0] = 1'b0;

      // Reset mid-load.
      feed_until(0, 7);
      rst = 1'b1;
      @(negedge prog_clk);
      rst = 1'b0;
      #1;
      check_all_zero(0, "t6");
      for (int i = 0; i < 3; i++) begin
         drive(0, 1'b1, 8'h5A);
         @(negedge prog_clk);
         #1;
         sample(0);
         check("t6_ready_held_low", 32'(s_ready), 0);
      end
      drive(0, 1'b0, 8'h00);
      pulse_start(0);
      #1;
      sample(0);
      check("t6_ready_after_start", 32'(s_ready), 1);
      abort_s[0] = 1'b1;
      @(negedge prog_clk);
      abort_s[0] = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
